sram32_ctrl: RTL and testbench

- Bus-to-pin controller for the external 32-bit asynchronous SRAM (22-bit word address, 4 byte lanes).
- Upstream side: a Wishbone-classic slave port. Downstream side: SRAM pins (address, data, CE#, OE#, WE#, BE#[3:0]).
- Sequences single-word reads and writes with programmable wait states and enforces bus turnaround.
- Pin tristating is done at the top level; this block exports separate data-out and output-enable signals.

---
 rtl/sram32_pkg.sv | 17 +
 rtl/sram32_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sram32_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sram32_pkg.sv
// Shared types and sizes for the external 32-bit asynchronous SRAM controller.
package sram32_pkg;

   localparam int SRAM_ADDR_W = 22;
   localparam int SRAM_DATA_W = 32;
   localparam int SRAM_LANES  = SRAM_DATA_W / 8;
   localparam int WAIT_W      = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_WHOLD = 3'd3,
      ST_TURN  = 3'd4
   } state_t;

endpackage

// File: rtl/sram32_ctrl.sv
// Wishbone-classic slave to asynchronous SRAM pin sequencer with programmable
// read/write wait states and a dead cycle between OE# release and data drive.
module sram32_ctrl
   import sram32_pkg::*;
#(
   parameter int ADDR_W     = SRAM_ADDR_W,
   parameter int DATA_W     = SRAM_DATA_W,
   parameter int READ_WAIT  = 2,
   parameter int WRITE_WAIT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wb_cyc,
   input  logic                wb_stb,
   input  logic                wb_we,
   input  logic [ADDR_W-1:0]   wb_adr,
   input  logic [DATA_W-1:0]   wb_dat_w,
   input  logic [DATA_W/8-1:0] wb_sel,
   output logic                wb_ack,
   output logic [DATA_W-1:0]   wb_dat_r,
   output logic [ADDR_W-1:0]   sram_adr,
   input  logic [DATA_W-1:0]   sram_d_i,
   output logic [DATA_W-1:0]   sram_d_o,
   output logic                sram_d_oe,
   output logic                sram_ce_n,
   output logic                sram_oe_n,
   output logic                sram_we_n,
   output logic [DATA_W/8-1:0] sram_be_n
);

   localparam int                LANES    = DATA_W / 8;
   localparam logic [WAIT_W-1:0] RD_WAIT  = WAIT_W'(READ_WAIT);
   localparam logic [WAIT_W-1:0] WR_WAIT  = WAIT_W'(WRITE_WAIT);
   localparam logic [WAIT_W-1:0] CNT_ZERO = {WAIT_W{1'b0}};
   localparam logic [WAIT_W-1:0] CNT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
   localparam logic [LANES-1:0]  BE_IDLE  = {LANES{1'b1}};

   state_t              r_state,  w_state_nxt;
   logic [WAIT_W-1:0]   r_cnt,    w_cnt_nxt;
   logic                r_ack,    w_ack_nxt;
   logic [DATA_W-1:0]   r_dat_r,  w_dat_r_nxt;
   logic [ADDR_W-1:0]   r_adr,    w_adr_nxt;
   logic [DATA_W-1:0]   r_d_o,    w_d_o_nxt;
   logic                r_d_oe,   w_d_oe_nxt;
   logic                r_ce_n,   w_ce_n_nxt;
   logic                r_oe_n,   w_oe_n_nxt;
   logic                r_we_n,   w_we_n_nxt;
   logic [LANES-1:0]    r_be_n,   w_be_n_nxt;

   // Next-state and next-pin computation; every output is re-registered below.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ack_nxt   = 1'b0;
      w_dat_r_nxt = r_dat_r;
      w_adr_nxt   = r_adr;
      w_d_o_nxt   = r_d_o;
      w_d_oe_nxt  = r_d_oe;
      w_ce_n_nxt  = r_ce_n;
      w_oe_n_nxt  = r_oe_n;
      w_we_n_nxt  = r_we_n;
      w_be_n_nxt  = r_be_n;
      case (r_state)
         ST_IDLE: begin
            if (wb_cyc && wb_stb) begin
               w_adr_nxt  = wb_adr;
               w_be_n_nxt = ~wb_sel;
               w_d_o_nxt  = wb_dat_w;
               w_ce_n_nxt = 1'b0;
               if (wb_we) begin
                  w_we_n_nxt  = 1'b0;
                  w_d_oe_nxt  = 1'b1;
                  w_cnt_nxt   = WR_WAIT;
                  w_state_nxt = ST_WRITE;
               end else begin
                  w_oe_n_nxt  = 1'b0;
                  w_cnt_nxt   = RD_WAIT;
                  w_state_nxt = ST_READ;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_READ: begin
            if (r_cnt == CNT_ZERO) begin
               // Pins are still driven by the SRAM here; OE# rises with this edge.
               w_dat_r_nxt = sram_d_i;
               w_ack_nxt   = wb_cyc;
               w_oe_n_nxt  = 1'b1;
               w_ce_n_nxt  = 1'b1;
               w_be_n_nxt  = BE_IDLE;
               w_state_nxt = ST_TURN;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         ST_WRITE: begin
            if (r_cnt == CNT_ZERO) begin
               w_we_n_nxt  = 1'b1;
               w_ack_nxt   = wb_cyc;
               w_state_nxt = ST_WHOLD;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         ST_WHOLD: begin
            w_d_oe_nxt  = 1'b0;
            w_ce_n_nxt  = 1'b1;
            w_be_n_nxt  = BE_IDLE;
            w_state_nxt = ST_IDLE;
         end
         ST_TURN: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_cnt_nxt   = CNT_ZERO;
            w_d_oe_nxt  = 1'b0;
            w_ce_n_nxt  = 1'b1;
            w_oe_n_nxt  = 1'b1;
            w_we_n_nxt  = 1'b1;
            w_be_n_nxt  = BE_IDLE;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= CNT_ZERO;
         r_ack   <= 1'b0;
         r_dat_r <= {DATA_W{1'b0}};
         r_adr   <= {ADDR_W{1'b0}};
         r_d_o   <= {DATA_W{1'b0}};
         r_d_oe  <= 1'b0;
         r_ce_n  <= 1'b1;
         r_oe_n  <= 1'b1;
         r_we_n  <= 1'b1;
         r_be_n  <= BE_IDLE;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ack   <= w_ack_nxt;
         r_dat_r <= w_dat_r_nxt;
         r_adr   <= w_adr_nxt;
         r_d_o   <= w_d_o_nxt;
         r_d_oe  <= w_d_oe_nxt;
         r_ce_n  <= w_ce_n_nxt;
         r_oe_n  <= w_oe_n_nxt;
         r_we_n  <= w_we_n_nxt;
         r_be_n  <= w_be_n_nxt;
      end
   end

   assign wb_ack    = r_ack;
   assign wb_dat_r  = r_dat_r;
   assign sram_adr  = r_adr;
   assign sram_d_o  = r_d_o;
   assign sram_d_oe = r_d_oe;
   assign sram_ce_n = r_ce_n;
   assign sram_oe_n = r_oe_n;
   assign sram_we_n = r_we_n;
   assign sram_be_n = r_be_n;

endmodule

// File: tb/tb_sram32_ctrl.sv
// Randomised bench for sram32_ctrl: two instances (2/2 and 0/0 wait states)
// checked against latency/pin rules and an address-echo SRAM pin model.
module tb_sram32_ctrl;

   localparam int RW0 = 2;
   localparam int WW0 = 2;
   localparam int RW1 = 0;
   localparam int WW1 = 0;

   logic        clk;
   logic        rst;
   logic [1:0]  cyc, stb;
   logic        we;
   logic [21:0] adr;
   logic [31:0] dat_w;
   logic [3:0]  sel;

   logic [1:0]  ack, d_oe, ce_n, oe_n, we_n;
   logic [31:0] dat_r [2];
   logic [21:0] s_adr [2];
   logic [31:0] d_o   [2];
   logic [31:0] d_i   [2];
   logic [3:0]  be_n  [2];

   int n_checks;
   int n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM pin model: echoes address + 0x1_0000 while OE# is low; floating bus reads as 0.
   assign d_i[0] = !oe_n[0] ? ({10'd0, s_adr[0]} + 32'h0001_0000) : 32'h0;
   assign d_i[1] = !oe_n[1] ? ({10'd0, s_adr[1]} + 32'h0001_0000) : 32'h0;

   sram32_ctrl #(.READ_WAIT(RW0), .WRITE_WAIT(WW0)) u_dut0 (
      .clk(clk), .rst(rst), .wb_cyc(cyc[0]), .wb_stb(stb[0]), .wb_we(we),
      .wb_adr(adr), .wb_dat_w(dat_w), .wb_sel(sel), .wb_ack(ack[0]),
      .wb_dat_r(dat_r[0]), .sram_adr(s_adr[0]), .sram_d_i(d_i[0]),
      .sram_d_o(d_o[0]), .sram_d_oe(d_oe[0]), .sram_ce_n(ce_n[0]),
      .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]), .sram_be_n(be_n[0])
   );

   sram32_ctrl #(.READ_WAIT(RW1), .WRITE_WAIT(WW1)) u_dut1 (
      .clk(clk), .rst(rst), .wb_cyc(cyc[1]), .wb_stb(stb[1]), .wb_we(we),
      .wb_adr(adr), .wb_dat_w(dat_w), .wb_sel(sel), .wb_ack(ack[1]),
      .wb_dat_r(dat_r[1]), .sram_adr(s_adr[1]), .sram_d_i(d_i[1]),
      .sram_d_o(d_o[1]), .sram_d_oe(d_oe[1]), .sram_ce_n(ce_n[1]),
      .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]), .sram_be_n(be_n[1])
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int wait_of(input int d, input bit is_wr);
      if (d == 0) return is_wr ? WW0 : RW0;
      return is_wr ? WW1 : RW1;
   endfunction

   task automatic check_reset_vals(input int d);
      check_eq("rst_ack",  64'(ack[d]),   64'd0);
      check_eq("rst_datr", 64'(dat_r[d]), 64'd0);
      check_eq("rst_adr",  64'(s_adr[d]), 64'd0);
      check_eq("rst_do",   64'(d_o[d]),   64'd0);
      check_eq("rst_doe",  64'(d_oe[d]),  64'd0);
      check_eq("rst_ce",   64'(ce_n[d]),  64'd1);
      check_eq("rst_oe",   64'(oe_n[d]),  64'd1);
      check_eq("rst_we",   64'(we_n[d]),  64'd1);
      check_eq("rst_be",   64'(be_n[d]),  64'hF);
   endtask

   // One bus transaction; the request is sampled at edge 0, cycle k follows edge k-1.
   task automatic run_txn(input int d, input bit t_we, input logic [21:0] t_adr,
                          input logic [31:0] t_dat, input logic [3:0] t_sel, input bit drop);
      int wt, ack_k, n_ack, oe_lo, we_lo, doe_hi;
      bit stable_ok;
      logic [31:0] got;
      wt = wait_of(d, t_we);
      ack_k = 0; n_ack = 0; oe_lo = 0; we_lo = 0; doe_hi = 0;
      stable_ok = 1'b1; got = 32'h0;
      @(negedge clk);
      we = t_we; adr = t_adr; dat_w = t_dat; sel = t_sel;
      cyc[d] = 1'b1; stb[d] = 1'b1;
      @(posedge clk); #1;
      stb[d] = 1'b0;
      for (int k = 1; k <= wt + 4; k++) begin
         if (drop && k == 1) cyc[d] = 1'b0;
         if (!oe_n[d]) oe_lo++;
         if (!we_n[d]) we_lo++;
         if (d_oe[d])  doe_hi++;
         if (!ce_n[d] && (s_adr[d] !== t_adr || be_n[d] !== ~t_sel)) stable_ok = 1'b0;
         if (d_oe[d] && d_o[d] !== t_dat) stable_ok = 1'b0;
         if (ack[d]) begin
            n_ack++;
            if (ack_k == 0) begin
               ack_k = k;
               got   = dat_r[d];
            end
            cyc[d] = 1'b0;
         end
         if (ack_k != 0) break;
         @(posedge clk); #1;
      end
      cyc[d] = 1'b0;
      @(posedge clk); #1;
      if (ack[d]) n_ack++;
      check_eq("after_ce", 64'(ce_n[d]), 64'd1);
      check_eq("after_be", 64'(be_n[d]), 64'hF);
      check_eq("after_doe", 64'(d_oe[d]), 64'd0);
      check_eq("stable_pins", 64'(stable_ok), 64'd1);
      if (drop) begin
         check_eq("drop_no_ack", 64'(n_ack), 64'd0);
      end else begin
         check_eq("ack_cycle", 64'(ack_k), 64'(wt + 2));
         check_eq("ack_pulses", 64'(n_ack), 64'd1);
      end
      if (t_we) begin
         check_eq("wr_we_low", 64'(we_lo), 64'(wt + 1));
         check_eq("wr_oe_low", 64'(oe_lo), 64'd0);
         check_eq("wr_doe_hi", 64'(doe_hi), 64'(wt + 2));
      end else begin
         check_eq("rd_oe_low", 64'(oe_lo), 64'(wt + 1));
         check_eq("rd_we_low", 64'(we_lo), 64'd0);
         check_eq("rd_doe_hi", 64'(doe_hi), 64'd0);
         if (!drop) check_eq("rd_data", 64'(got), 64'({10'd0, t_adr} + 32'h0001_0000));
      end
   endtask

   // Pin-level invariants on both instances, sampled every falling edge.
   initial begin
      int cyc_no;
      int last_rise [2];
      logic prev_oe [2];
      logic prev_doe [2];
      cyc_no = 0;
      for (int d = 0; d < 2; d++) begin
         last_rise[d] = -100; prev_oe[d] = 1'b1; prev_doe[d] = 1'b0;
      end
      forever begin
         @(negedge clk);
         cyc_no++;
         for (int d = 0; d < 2; d++) begin
            if (!oe_n[d] && !we_n[d]) check_eq("oe_we_overlap", 64'd1, 64'd0);
            if (d_oe[d] && !oe_n[d])  check_eq("doe_oe_overlap", 64'd1, 64'd0);
            if (!prev_oe[d] && oe_n[d]) last_rise[d] = cyc_no;
            if (!prev_doe[d] && d_oe[d])
               check_eq("turnaround_ge2", 64'(cyc_no - last_rise[d] >= 2), 64'd1);
            prev_oe[d]  = oe_n[d];
            prev_doe[d] = d_oe[d];
         end
      end
   end

   initial begin
      int n_ack_rst;
      n_checks = 0; n_fail = 0;
      rst = 1'b1; cyc = 2'b00; stb = 2'b00; we = 1'b0;
      adr = 22'h0; dat_w = 32'h0; sel = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals(0);
      check_reset_vals(1);
      @(negedge clk);
      rst = 1'b0;

      run_txn(0, 1'b0, 22'h000123, 32'h0, 4'hF, 1'b0);
      run_txn(0, 1'b1, 22'h3FFFFF, 32'hDEADBEEF, 4'hF, 1'b0);
      run_txn(0, 1'b0, 22'h000010, 32'h0, 4'hF, 1'b0);
      run_txn(0, 1'b1, 22'h000010, 32'h12345678, 4'hF, 1'b0);
      run_txn(0, 1'b1, 22'h000200, 32'hA5A5A5A5, 4'h5, 1'b0);
      run_txn(0, 1'b1, 22'h000201, 32'h5A5A5A5A, 4'h0, 1'b0);
      run_txn(1, 1'b0, 22'h0ABCDE, 32'h0, 4'hF, 1'b0);
      run_txn(1, 1'b1, 22'h000333, 32'hCAFEF00D, 4'h3, 1'b0);
      run_txn(1, 1'b0, 22'h000334, 32'h0, 4'hF, 1'b0);
      run_txn(0, 1'b0, 22'h000055, 32'h0, 4'hF, 1'b1);

      // Reset during the second READ cycle.
      @(negedge clk);
      we = 1'b0; adr = 22'h000077; sel = 4'hF; cyc[0] = 1'b1; stb[0] = 1'b1;
      @(posedge clk); #1;
      stb[0] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_vals(0);
      rst = 1'b0; cyc[0] = 1'b0;
      n_ack_rst = 0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         if (ack[0]) n_ack_rst++;
      end
      check_eq("rst_no_ack", 64'(n_ack_rst), 64'd0);
      run_txn(0, 1'b0, 22'h000001, 32'h0, 4'hF, 1'b0);

      for (int i = 0; i < 40; i++) begin
         run_txn(int'($urandom_range(0, 1)), 1'($urandom), 22'($urandom),
                 $urandom, 4'($urandom), (i % 7) == 3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
